// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the pipeline stages / CSR unit.
// Member names keep the original pipe_ctrl port names.
interface pipe_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        branch_req_i;
  logic [31:0] branch_target_i;
  logic        trap_req_i;
  logic [31:0] trap_target_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        new_pc_we_o;
  logic        trap_ack_o;
  logic [31:0] stall_cnt_o;

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  branch_req_i, branch_target_i, trap_req_i, trap_target_i,
    output stall_o, flush_o, new_pc_o, new_pc_we_o, trap_ack_o, stall_cnt_o
  );

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output branch_req_i, branch_target_i, trap_req_i, trap_target_i,
    input  stall_o, flush_o, new_pc_o, new_pc_we_o, trap_ack_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall requests, sequences trap/mret redirection
// (drain -> flush -> hold), drives branch redirects and a stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         n_rst_i,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_hold_cnt;
  logic [3:0]  w_hold_nxt;
  logic [31:0] r_target;
  logic [31:0] r_new_pc;
  logic [31:0] r_stall_cnt;
  logic [5:0]  w_req_vec;
  logic [5:0]  w_stall;
  logic        w_branch;
  logic        w_branch_act;
  logic        w_pc_we;
  logic [31:0] w_new_pc;

  // Deepest requesting stage wins; everything upstream of it stops too.
  always_comb begin
    w_req_vec = '0;
    if (bus.stallreq_mem_i)     w_req_vec = 6'b011111;
    else if (bus.stallreq_ex_i) w_req_vec = 6'b001111;
    else if (bus.stallreq_id_i) w_req_vec = 6'b000111;
    else if (bus.stallreq_if_i) w_req_vec = 6'b000011;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_stall     = w_req_vec;
    w_branch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.trap_req_i) begin
          w_stall     = w_req_vec | 6'b001111;
          w_state_nxt = bus.stallreq_mem_i ? S_DRAIN : S_FLUSH;
        end else begin
          w_branch = bus.branch_req_i;
        end
      end
      S_DRAIN: begin
        w_stall = w_req_vec | 6'b001111;
        if (!bus.stallreq_mem_i) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_stall = '0;
        if (FLUSH_CYCLES <= 1) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = 4'(FLUSH_CYCLES - 1);
        end
      end
      S_HOLD: begin
        w_stall = '0;
        if (r_hold_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Combinational paths are gated by reset so nothing escapes while held.
  assign w_branch_act = w_branch & n_rst_i;
  assign w_pc_we      = (r_state == S_FLUSH) | w_branch_act;
  assign w_new_pc     = (r_state == S_FLUSH) ? r_target :
                        w_branch_act         ? bus.branch_target_i : r_new_pc;

  assign bus.stall_o     = n_rst_i ? w_stall : '0;
  assign bus.flush_o     = (r_state == S_FLUSH) | (r_state == S_HOLD);
  assign bus.trap_ack_o  = (r_state == S_FLUSH);
  assign bus.new_pc_we_o = w_pc_we;
  assign bus.new_pc_o    = w_new_pc;
  assign bus.stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= '0;
      r_target    <= RESET_PC;
      r_new_pc    <= RESET_PC;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_state_nxt == S_FLUSH && r_state != S_FLUSH)
        r_target <= bus.trap_target_i;
      if (w_pc_we)
        r_new_pc <= w_new_pc;
      if (bus.stall_o != '0 && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of IDLE-state vectors plus hand-written
// reset, trap, drain, branch-vs-trap and counter-saturation sequences.
module tb_pipe_ctrl;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_errors;

  pipe_ctrl_if if1 ();
  pipe_ctrl_if if3 ();

  pipe_ctrl #(.FLUSH_CYCLES(1), .RESET_PC(32'h0000_1000)) u_dut1 (
    .clk_i   (clk),
    .n_rst_i (n_rst),
    .bus     (if1.slave)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .RESET_PC(32'h0000_0000)) u_dut3 (
    .clk_i   (clk),
    .n_rst_i (n_rst),
    .bus     (if3.slave)
  );

  assign if3.stallreq_if_i   = if1.stallreq_if_i;
  assign if3.stallreq_id_i   = if1.stallreq_id_i;
  assign if3.stallreq_ex_i   = if1.stallreq_ex_i;
  assign if3.stallreq_mem_i  = if1.stallreq_mem_i;
  assign if3.branch_req_i    = if1.branch_req_i;
  assign if3.branch_target_i = if1.branch_target_i;
  assign if3.trap_req_i      = if1.trap_req_i;
  assign if3.trap_target_i   = if1.trap_target_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0]  req;   // {mem, ex, id, if}
    logic        br;
    logic [31:0] btgt;
    logic [5:0]  stall;
    logic        we;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if1.stallreq_if_i   = 1'b0;
    if1.stallreq_id_i   = 1'b0;
    if1.stallreq_ex_i   = 1'b0;
    if1.stallreq_mem_i  = 1'b0;
    if1.branch_req_i    = 1'b0;
    if1.branch_target_i = '0;
    if1.trap_req_i      = 1'b0;
    if1.trap_target_i   = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_rst    = 1'b0;
    clear_inputs();

    tv[0] = '{4'b0000, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h0000_1000, 32'd0};
    tv[1] = '{4'b0010, 1'b0, 32'h0,  6'b000111, 1'b0, 32'h0000_1000, 32'd0};
    tv[2] = '{4'b1010, 1'b0, 32'h0,  6'b011111, 1'b0, 32'h0000_1000, 32'd1};
    tv[3] = '{4'b0001, 1'b0, 32'h0,  6'b000011, 1'b0, 32'h0000_1000, 32'd2};
    tv[4] = '{4'b0100, 1'b0, 32'h0,  6'b001111, 1'b0, 32'h0000_1000, 32'd3};
    tv[5] = '{4'b0000, 1'b1, 32'h40, 6'b000000, 1'b1, 32'h0000_0040, 32'd4};
    tv[6] = '{4'b0000, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h0000_0040, 32'd4};
    tv[7] = '{4'b0100, 1'b1, 32'h80, 6'b001111, 1'b1, 32'h0000_0080, 32'd4};
    tv[8] = '{4'b0000, 1'b0, 32'h0,  6'b000000, 1'b0, 32'h0000_0080, 32'd5};

    // Start a trap that drains, then reset it mid-cycle with everything asserted.
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    if1.trap_req_i     = 1'b1;
    if1.stallreq_mem_i = 1'b1;
    if1.trap_target_i  = 32'hCAFE_0000;
    @(negedge clk);
    @(posedge clk);
    #3;
    if1.stallreq_if_i = 1'b1;
    if1.stallreq_id_i = 1'b1;
    if1.stallreq_ex_i = 1'b1;
    if1.branch_req_i  = 1'b1;
    n_rst = 1'b0;
    #1;
    chk("rst_stall", 32'(if1.stall_o), 32'h0);
    chk("rst_flush", 32'(if1.flush_o), 32'h0);
    chk("rst_ack",   32'(if1.trap_ack_o), 32'h0);
    chk("rst_we",    32'(if1.new_pc_we_o), 32'h0);
    chk("rst_pc",    if1.new_pc_o, 32'h0000_1000);
    chk("rst_cnt",   if1.stall_cnt_o, 32'h0);
    chk("rst_flush3", 32'(if3.flush_o), 32'h0);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    n_rst = 1'b1;

    // IDLE-state priority / branch / counter vectors.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      {if1.stallreq_mem_i, if1.stallreq_ex_i, if1.stallreq_id_i, if1.stallreq_if_i} = tv[i].req;
      if1.branch_req_i    = tv[i].br;
      if1.branch_target_i = tv[i].btgt;
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(if1.stall_o), 32'(tv[i].stall));
      chk($sformatf("vec%0d_we", i),    32'(if1.new_pc_we_o), 32'(tv[i].we));
      chk($sformatf("vec%0d_pc", i),    if1.new_pc_o, tv[i].pc);
      chk($sformatf("vec%0d_flush", i), 32'(if1.flush_o), 32'h0);
      chk($sformatf("vec%0d_cnt", i),   if1.stall_cnt_o, tv[i].cnt);
    end

    // Trap without drain; FLUSH_CYCLES=3 instance holds flush for three cycles.
    @(negedge clk);
    clear_inputs();
    if1.trap_req_i    = 1'b1;
    if1.trap_target_i = 32'h8000_0100;
    #1;
    chk("trap_pre_stall", 32'(if1.stall_o), 32'h0F);
    chk("trap_pre_flush", 32'(if1.flush_o), 32'h0);
    chk("trap_pre_we",    32'(if1.new_pc_we_o), 32'h0);
    @(negedge clk);
    if1.stallreq_id_i = 1'b1;
    #1;
    chk("trap_flush",  32'(if1.flush_o), 32'h1);
    chk("trap_ack",    32'(if1.trap_ack_o), 32'h1);
    chk("trap_we",     32'(if1.new_pc_we_o), 32'h1);
    chk("trap_pc",     if1.new_pc_o, 32'h8000_0100);
    chk("trap_stall",  32'(if1.stall_o), 32'h0);
    chk("trap_flush3", 32'(if3.flush_o), 32'h1);
    if1.trap_req_i = 1'b0;
    @(negedge clk);
    #1;
    chk("trap_n2_flush",  32'(if1.flush_o), 32'h0);
    chk("trap_n2_ack",    32'(if1.trap_ack_o), 32'h0);
    chk("trap_n2_we",     32'(if1.new_pc_we_o), 32'h0);
    chk("trap_n2_pc",     if1.new_pc_o, 32'h8000_0100);
    chk("trap_n2_stall",  32'(if1.stall_o), 32'h07);
    chk("hold1_flush3",   32'(if3.flush_o), 32'h1);
    chk("hold1_ack3",     32'(if3.trap_ack_o), 32'h0);
    chk("hold1_we3",      32'(if3.new_pc_we_o), 32'h0);
    chk("hold1_stall3",   32'(if3.stall_o), 32'h0);
    @(negedge clk);
    #1;
    chk("hold2_flush3", 32'(if3.flush_o), 32'h1);
    @(negedge clk);
    #1;
    chk("hold_end_flush3", 32'(if3.flush_o), 32'h0);
    chk("hold_end_stall3", 32'(if3.stall_o), 32'h07);
    if1.stallreq_id_i = 1'b0;

    // Trap behind a MEM stall: three drain cycles, then FLUSH with latched target.
    @(negedge clk);
    if1.stallreq_mem_i = 1'b1;
    if1.trap_req_i     = 1'b1;
    if1.trap_target_i  = 32'h8000_0200;
    #1;
    chk("drain1_stall", 32'(if1.stall_o), 32'h1F);
    @(negedge clk);
    if1.branch_req_i    = 1'b1;
    if1.branch_target_i = 32'h0000_0044;
    #1;
    chk("drain2_stall", 32'(if1.stall_o), 32'h1F);
    chk("drain2_we",    32'(if1.new_pc_we_o), 32'h0);
    chk("drain2_pc",    if1.new_pc_o, 32'h8000_0100);
    chk("drain2_flush", 32'(if1.flush_o), 32'h0);
    @(negedge clk);
    #1;
    chk("drain3_stall", 32'(if1.stall_o), 32'h1F);
    #1;
    if1.stallreq_mem_i = 1'b0;
    if1.branch_req_i   = 1'b0;
    @(negedge clk);
    if1.trap_target_i = 32'hDEAD_0000;
    #1;
    chk("drain_flush",  32'(if1.flush_o), 32'h1);
    chk("drain_ack",    32'(if1.trap_ack_o), 32'h1);
    chk("drain_pc",     if1.new_pc_o, 32'h8000_0200);
    chk("drain_stall",  32'(if1.stall_o), 32'h0);
    if1.trap_req_i = 1'b0;
    @(negedge clk);
    #1;
    chk("drain_post_flush", 32'(if1.flush_o), 32'h0);
    repeat (3) @(negedge clk);

    // Branch and trap together: trap wins.
    if1.branch_req_i    = 1'b1;
    if1.branch_target_i = 32'h0000_0040;
    if1.trap_req_i      = 1'b1;
    if1.trap_target_i   = 32'h8000_0300;
    #1;
    chk("bt_we",    32'(if1.new_pc_we_o), 32'h0);
    chk("bt_pc",    if1.new_pc_o, 32'h8000_0200);
    chk("bt_stall", 32'(if1.stall_o), 32'h0F);
    chk("bt_flush", 32'(if1.flush_o), 32'h0);
    @(negedge clk);
    #1;
    chk("bt_fl_flush", 32'(if1.flush_o), 32'h1);
    chk("bt_fl_we",    32'(if1.new_pc_we_o), 32'h1);
    chk("bt_fl_pc",    if1.new_pc_o, 32'h8000_0300);
    clear_inputs();
    @(negedge clk);
    #1;
    chk("bt_post_we", 32'(if1.new_pc_we_o), 32'h0);
    chk("bt_post_pc", if1.new_pc_o, 32'h8000_0300);
    repeat (3) @(negedge clk);

    // Counter saturation.
    force u_dut1.r_stall_cnt = 32'hFFFF_FFFE;
    if1.stallreq_ex_i = 1'b1;
    #1;
    release u_dut1.r_stall_cnt;
    #1;
    chk("sat_pre", if1.stall_cnt_o, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("sat_%0d", k), if1.stall_cnt_o, 32'hFFFF_FFFF);
    end
    clear_inputs();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
